// File: rtl/rx_pkt_marker.sv
// rx_pkt_marker: inline AXI-stream stage that optionally stamps each packet's
// last beat with a running packet index, and in fill mode replaces the
// non-last beats with a constant pattern. A two-entry skid buffer keeps full
// throughput while s_tready depends only on registered state.
//
// state | meaning
// EMPTY | no beat held, m_tvalid low
// ONE   | main register holds a beat, skid register empty
// TWO   | main and skid registers both hold beats, s_tready low
module rx_pkt_marker #(
  parameter int                WIDTH          = 32,
  parameter int                USER_WIDTH     = 128,
  parameter logic [WIDTH-1:0]  FILL_WORD      = 32'hABCD_BEEF,
  parameter logic [7:0]        SR_MARKER_CTRL = 8'd200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  set_stb,
  input  logic [7:0]            set_addr,
  input  logic [31:0]           set_data,
  input  logic [WIDTH-1:0]      s_tdata,
  input  logic [USER_WIDTH-1:0] s_tuser,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [WIDTH-1:0]      m_tdata,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [31:0]           marker_count
);

  localparam logic [1:0] MODE_MARK = 2'd1;
  localparam logic [1:0] MODE_FILL = 2'd2;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  occ_t                  state;
  logic [1:0]            mode_pending;
  logic [1:0]            mode_act;
  logic                  first_beat;
  logic [31:0]           cnt_q;
  logic [WIDTH-1:0]      skid_data;
  logic [USER_WIDTH-1:0] skid_user;
  logic                  skid_last;

  logic                  in_acc;
  logic                  out_acc;
  logic                  ctrl_wr;
  logic                  cnt_clr;
  logic [1:0]            beat_mode;
  logic [WIDTH-1:0]      x_data;
  logic                  unused_set_bits;

  assign in_acc          = s_tvalid & s_tready;
  assign out_acc         = m_tvalid & m_tready;
  assign ctrl_wr         = set_stb && (set_addr == SR_MARKER_CTRL);
  assign cnt_clr         = ctrl_wr && set_data[31];
  // A packet's first beat picks up the pending mode in the same cycle it is accepted.
  assign beat_mode       = first_beat ? mode_pending : mode_act;
  assign marker_count    = cnt_q;
  assign unused_set_bits = ^set_data[30:2];

  // Transform the incoming beat according to the mode in force for its packet.
  always_comb begin
    x_data = s_tdata;
    if (s_tlast && (beat_mode == MODE_MARK || beat_mode == MODE_FILL)) begin
      x_data = WIDTH'(cnt_q);
    end else if (!s_tlast && beat_mode == MODE_FILL) begin
      x_data = FILL_WORD;
    end
  end

  // Control register, mode shadowing and packet counter (clear beats increment).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_pending <= 2'd0;
      mode_act     <= 2'd0;
      first_beat   <= 1'b1;
      cnt_q        <= 32'd0;
    end else begin
      if (ctrl_wr) mode_pending <= set_data[1:0];
      if (in_acc) begin
        if (first_beat) mode_act <= mode_pending;
        first_beat <= s_tlast;
      end
      if (cnt_clr) cnt_q <= 32'd0;
      else if (in_acc && s_tlast) cnt_q <= cnt_q + 32'd1;
    end
  end

  // Skid-buffer occupancy FSM with registered outputs and registered s_tready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      s_tready  <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tuser   <= '0;
      m_tlast   <= 1'b0;
      skid_data <= '0;
      skid_user <= '0;
      skid_last <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          s_tready <= 1'b1;
          if (in_acc) begin
            m_tdata  <= x_data;
            m_tuser  <= s_tuser;
            m_tlast  <= s_tlast;
            m_tvalid <= 1'b1;
            state    <= ONE;
          end
        end
        ONE: begin
          if (in_acc && out_acc) begin
            m_tdata <= x_data;
            m_tuser <= s_tuser;
            m_tlast <= s_tlast;
          end else if (in_acc) begin
            skid_data <= x_data;
            skid_user <= s_tuser;
            skid_last <= s_tlast;
            s_tready  <= 1'b0;
            state     <= TWO;
          end else if (out_acc) begin
            m_tvalid <= 1'b0;
            state    <= EMPTY;
          end
        end
        TWO: begin
          if (out_acc) begin
            m_tdata  <= skid_data;
            m_tuser  <= skid_user;
            m_tlast  <= skid_last;
            s_tready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state    <= EMPTY;
          s_tready <= 1'b1;
          m_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_pkt_marker.sv
// Testbench for rx_pkt_marker: directed packet table, mid-packet mode change,
// counter wrap and clear corners, randomized backpressure against a packet-level
// reference model, and asynchronous reset mid-packet.
module tb_rx_pkt_marker;

  localparam logic [31:0] FILL = 32'hABCD_BEEF;
  localparam logic [7:0]  SR   = 8'd200;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         set_stb = 1'b0;
  logic [7:0]   set_addr = '0;
  logic [31:0]  set_data = '0;
  logic [31:0]  s_tdata = '0;
  logic [127:0] s_tuser = '0;
  logic         s_tlast = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [31:0]  m_tdata;
  logic [127:0] m_tuser;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic [31:0]  marker_count;

  rx_pkt_marker dut (
    .clk(clk), .reset_n(reset_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .marker_count(marker_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  data;
    logic [127:0] user;
    logic         last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t out_log[$];
  logic  live;
  bit    ovr = 1'b0;

  // reference model state, in packet terms
  logic [31:0] cnt_m = '0;
  logic [1:0]  pend_m = '0;
  logic [1:0]  act_m = '0;
  bit          first_m = 1'b1;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // Tracks whether at least one clock edge has passed since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Scoreboard: sampled mid-cycle, models what each upcoming clock edge does.
  always @(negedge clk) begin
    beat_t b;
    logic [1:0] eff;
    if (!reset_n) begin
      exp_q.delete();
      cnt_m = '0; pend_m = '0; act_m = '0; first_m = 1'b1;
    end else if (live) begin
      if (ovr) cnt_m = 32'hFFFF_FFFF;
      chk("m_tvalid_vs_held", {127'd0, m_tvalid}, {127'd0, exp_q.size() > 0});
      chk("s_tready_vs_held", {127'd0, s_tready}, {127'd0, exp_q.size() < 2});
      chk("marker_count", {96'd0, marker_count}, {96'd0, cnt_m});
      if (m_tvalid && m_tready) begin
        b.data = m_tdata; b.user = m_tuser; b.last = m_tlast;
        out_log.push_back(b);
        if (exp_q.size() == 0) begin
          chk("out_without_in", 128'd1, 128'd0);
        end else begin
          chk("out_data", {96'd0, m_tdata}, {96'd0, exp_q[0].data});
          chk("out_user", m_tuser, exp_q[0].user);
          chk("out_last", {127'd0, m_tlast}, {127'd0, exp_q[0].last});
          void'(exp_q.pop_front());
        end
      end
      if (s_tvalid && s_tready) begin
        eff = first_m ? pend_m : act_m;
        if (first_m) act_m = pend_m;
        b.data = s_tdata; b.user = s_tuser; b.last = s_tlast;
        if (s_tlast && (eff == 2'd1 || eff == 2'd2)) b.data = cnt_m;
        else if (!s_tlast && eff == 2'd2) b.data = FILL;
        exp_q.push_back(b);
        first_m = s_tlast;
      end
      if (set_stb && set_addr == SR) pend_m = set_data[1:0];
      if (set_stb && set_addr == SR && set_data[31]) cnt_m = '0;
      else if (s_tvalid && s_tready && s_tlast) cnt_m = cnt_m + 32'd1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the last beat is accepted.
  task automatic send_pkt(input int n, input logic [31:0] base, input int wr_at,
                          input logic [31:0] wr_data);
    for (int i = 0; i < n; i++) begin
      int k;
      s_tvalid = 1'b1;
      s_tdata  = base + 32'(i);
      s_tuser  = {$urandom, $urandom, $urandom, $urandom};
      s_tlast  = (i == n - 1);
      if (i == wr_at) begin
        set_stb = 1'b1; set_addr = SR; set_data = wr_data;
      end
      for (k = 0; k < 100; k++) begin
        @(negedge clk);
        if (s_tready) break;
      end
      if (k == 100) chk("send_timeout", 128'd1, 128'd0);
      @(posedge clk); #1;
      set_stb = 1'b0;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!m_tvalid) break;
    end
    if (k == 200) chk("drain_timeout", 128'd1, 128'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          do_wr;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    int          n;
    logic [31:0] base;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int b;
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    vecs[0] = '{1'b1, SR,    32'h0000_0001, 4, 32'h100, 32'h100, 32'd0,   32'd1};
    vecs[1] = '{1'b0, SR,    32'h0,         4, 32'h200, 32'h200, 32'd1,   32'd2};
    vecs[2] = '{1'b0, SR,    32'h0,         4, 32'h300, 32'h300, 32'd2,   32'd3};
    vecs[3] = '{1'b1, SR,    32'h0000_0000, 2, 32'h400, 32'h400, 32'h401, 32'd4};
    vecs[4] = '{1'b1, SR,    32'h0000_0003, 1, 32'h500, 32'h500, 32'h500, 32'd5};
    vecs[5] = '{1'b1, SR,    32'h0000_0002, 2, 32'h600, FILL,    32'd5,   32'd6};
    vecs[6] = '{1'b1, 8'd199, 32'h0000_0001, 3, 32'h700, FILL,   32'd6,   32'd7};
    vecs[7] = '{1'b1, SR,    32'h8000_0001, 2, 32'h800, 32'h800, 32'd0,   32'd1};
    vecs[8] = '{1'b1, SR,    32'h0000_0002, 1, 32'h900, 32'd1,   32'd1,   32'd2};

    // reset values
    #12;
    chk("rst_m_tvalid", {127'd0, m_tvalid}, 128'd0);
    chk("rst_m_tdata", {96'd0, m_tdata}, 128'd0);
    chk("rst_m_tuser", m_tuser, 128'd0);
    chk("rst_m_tlast", {127'd0, m_tlast}, 128'd0);
    chk("rst_count", {96'd0, marker_count}, 128'd0);
    chk("rst_s_tready", {127'd0, s_tready}, 128'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("s_tready_before_edge", {127'd0, s_tready}, 128'd0);
    @(posedge clk); #1;
    chk("s_tready_after_edge", {127'd0, s_tready}, 128'd1);

    // directed packet table
    foreach (vecs[v]) begin
      if (vecs[v].do_wr) write_reg(vecs[v].wr_addr, vecs[v].wr_data);
      b = out_log.size();
      send_pkt(vecs[v].n, vecs[v].base, -1, 32'd0);
      wait_drain();
      chk($sformatf("vec%0d_beats", v), 128'(out_log.size() - b), 128'(vecs[v].n));
      if (out_log.size() >= b + vecs[v].n) begin
        chk($sformatf("vec%0d_first", v), {96'd0, out_log[b].data}, {96'd0, vecs[v].exp_first});
        chk($sformatf("vec%0d_last", v), {96'd0, out_log[b + vecs[v].n - 1].data},
            {96'd0, vecs[v].exp_last});
      end
      chk($sformatf("vec%0d_count", v), {96'd0, marker_count}, {96'd0, vecs[v].exp_cnt});
    end

    // mode written 0 -> 1 on the 2nd beat of a packet: that packet passes
    write_reg(SR, 32'd0);
    b = out_log.size();
    send_pkt(4, 32'hA00, 1, 32'd1);
    send_pkt(2, 32'hB00, -1, 32'd0);
    wait_drain();
    if (out_log.size() >= b + 6) begin
      chk("midwr_pkt_last", {96'd0, out_log[b + 3].data}, {96'd0, 32'hA03});
      chk("midwr_next_first", {96'd0, out_log[b + 4].data}, {96'd0, 32'hB00});
      chk("midwr_next_last", {96'd0, out_log[b + 5].data}, {96'd0, 32'd3});
    end else chk("midwr_beats", 128'(out_log.size() - b), 128'd6);

    // counter wrap from FFFF_FFFF, then clear coinciding with a tlast accept
    force dut.cnt_q = 32'hFFFF_FFFF;
    ovr = 1'b1;
    @(negedge clk); #1;
    release dut.cnt_q;
    ovr = 1'b0;
    @(posedge clk); #1;
    b = out_log.size();
    send_pkt(1, 32'hC00, -1, 32'd0);
    send_pkt(1, 32'hC01, -1, 32'd0);
    send_pkt(1, 32'hC02, 0, 32'h8000_0001);
    wait_drain();
    if (out_log.size() >= b + 3) begin
      chk("wrap_stamp", {96'd0, out_log[b].data}, {96'd0, 32'hFFFF_FFFF});
      chk("after_wrap_stamp", {96'd0, out_log[b + 1].data}, 128'd0);
      chk("clr_tlast_stamp", {96'd0, out_log[b + 2].data}, 128'd1);
    end else chk("wrap_beats", 128'(out_log.size() - b), 128'd3);
    chk("clr_tlast_count", {96'd0, marker_count}, 128'd0);

    // random backpressure and settings writes, continuous input
    begin
      int idx = 0;
      int len = 3;
      bit acc;
      s_tvalid = 1'b1;
      s_tdata = $urandom; s_tuser = {$urandom, $urandom, $urandom, $urandom};
      s_tlast = (len == 1);
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        acc = s_tready;
        @(posedge clk); #1;
        set_stb  = ($urandom_range(0, 15) == 0);
        set_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : SR;
        set_data = {($urandom_range(0, 7) == 0), 29'($urandom), 2'($urandom)};
        m_tready = $urandom_range(0, 1);
        if (acc) begin
          if (s_tlast) begin
            len = $urandom_range(1, 5);
            idx = 0;
          end else idx++;
          s_tdata = $urandom;
          s_tuser = {$urandom, $urandom, $urandom, $urandom};
          s_tlast = (idx == len - 1);
        end
      end
      set_stb = 1'b0;
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      wait_drain();
    end

    // reset mid-packet with downstream stalled
    send_pkt(1, 32'hE00, 0, 32'h0000_0001);
    wait_drain();
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 32'hF00; s_tlast = 1'b0;
    @(posedge clk); #1;
    s_tdata = 32'hF01;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    chk("pre_rst_held", {127'd0, m_tvalid}, 128'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_m_tvalid", {127'd0, m_tvalid}, 128'd0);
    chk("async_count", {96'd0, marker_count}, 128'd0);
    chk("async_s_tready", {127'd0, s_tready}, 128'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    m_tready = 1'b1;
    @(posedge clk); #1;
    b = out_log.size();
    send_pkt(3, 32'hD00, -1, 32'd0);
    wait_drain();
    if (out_log.size() >= b + 3) begin
      chk("post_rst_first", {96'd0, out_log[b].data}, {96'd0, 32'hD00});
      chk("post_rst_last", {96'd0, out_log[b + 2].data}, {96'd0, 32'hD02});
    end else chk("post_rst_beats", 128'(out_log.size() - b), 128'd3);
    chk("post_rst_count", {96'd0, marker_count}, 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
